// File: rtl/counter_pkg.sv
// Shared constants and sizing helper for the generic counter and its prescaler.
package counter_pkg;

  // End-of-range behaviour selector for the SATURATE parameter.
  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  // Values of the up_down input.
  localparam logic CNT_DOWN = 1'b0;
  localparam logic CNT_UP   = 1'b1;

  // Number of bits needed to hold 0..value-1, never less than one bit.
  function automatic int clog2(input longint unsigned value);
    int bits;
    bits = 1;
    for (int i = 1; i < 63; i++) begin
      if ((64'd1 << i) < value) begin
        bits = i + 1;
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Clock-enable prescaler: asserts tick on every PRESCALE-th enabled cycle.
// The phase only advances while enable is high, so pausing enable keeps the
// position within the current division period.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  if (PRESCALE <= 1) begin : g_bypass
    // No division: every enabled cycle is a count step, so no state is kept.
    logic unused_ok;
    assign unused_ok = &{1'b0, clock, reset, enable, clear};
    assign tick = 1'b1;
  end else begin : g_divide
    localparam int                PW   = clog2(PRESCALE);
    localparam logic [PW-1:0]     LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    // Next phase: clear restarts the period, enable advances it modulo PRESCALE.
    always_comb begin
      phase_d = phase_q;
      if (clear) begin
        phase_d = '0;
      end else if (enable) begin
        phase_d = (phase_q == LAST) ? '0 : phase_q + PW'(1);
      end
    end

    // Phase register, returned to the start of a period by reset.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        phase_q <= '0;
      end else begin
        phase_q <= phase_d;
      end
    end

    // Tick on the last enabled cycle of each period.
    assign tick = enable & (phase_q == LAST);
  end

endmodule

// File: rtl/counter_mod.sv
// Generic modulo counter: up/down, clear/load, wrap or saturate at the range
// limits, optional prescaled clock enable, terminal-count pulse and a sticky
// overflow flag.
module counter_mod
  import counter_pkg::*;
#(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 16,
  parameter int     SATURATE = CNT_WRAP,
  parameter int     PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             ovf_clear,
  output logic [WIDTH-1:0] counter_out,
  output logic             tc,
  output logic             overflow
);

  // Largest legal count; for MODULUS == 2**WIDTH this is all ones and the
  // wrap becomes the natural rollover.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             tc_d;
  logic             overflow_q;
  logic             overflow_d;

  logic tick;
  logic step;
  logic at_max;
  logic at_min;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .clear  (clear),
    .tick   (tick)
  );

  assign step   = enable & tick;
  assign at_max = (count_q == MAX_VAL);
  assign at_min = (count_q == '0);

  // Next count and terminal-count event; clear beats load, load beats a step.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = (load_value > MAX_VAL) ? MAX_VAL : load_value;
    end else if (step) begin
      case (up_down)
        CNT_UP: begin
          if (at_max) begin
            tc_d    = 1'b1;
            count_d = (SATURATE == CNT_WRAP) ? '0 : count_q;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
        CNT_DOWN: begin
          if (at_min) begin
            tc_d    = 1'b1;
            count_d = (SATURATE == CNT_WRAP) ? MAX_VAL : count_q;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
        default: count_d = count_q;
      endcase
    end
  end

  // Sticky overflow: a limit event wins over a simultaneous ovf_clear.
  always_comb begin
    overflow_d = overflow_q;
    if (tc_d) begin
      overflow_d = 1'b1;
    end else if (ovf_clear) begin
      overflow_d = 1'b0;
    end
  end

  // Count, terminal-count and overflow registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q    <= '0;
      tc_q       <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      tc_q       <= tc_d;
      overflow_q <= overflow_d;
    end
  end

  assign counter_out = count_q;
  assign tc          = tc_q;
  assign overflow    = overflow_q;

endmodule
